muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit adding RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) to the 5-stage pipeline. It is launched from execute with a valid/ready handshake. Decode stalls while `in_ready` is low. The result returns with its destination tag to the X/M boundary through a second valid/ready handshake.
- Operand width and bits retired per cycle are configurable.
- Divide-by-zero and signed overflow take a single-cycle fast path.
- A branch/jump flush aborts an in-flight operation.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, bits processed per RUN cycle. Legal values are 1, 2, 4, and the value must divide XLEN. ITER = XLEN/BITS_PER_CYCLE.
- TAG_W, 5, destination-register tag width.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  synchronous abort (branch/jump taken in execute).
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_funct3  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_rs1  in  XLEN  operand A (dividend / multiplicand).
- in_rs2  in  XLEN  operand B (divisor / multiplier).
- in_tag  in  TAG_W  destination register.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag captured at accept.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, RUN, FIX, DONE. Reset (reset=0, asynchronous) forces:
  - state=IDLE, counter=0, datapath registers=0;
  - out_valid=0, out_result=0, out_tag=0, busy=0, in_ready=1.
- Accept: the rising edge where state==IDLE && in_valid && !flush.
  - Latch funct3, tag, and the operand sign flags.
  - Latch operand magnitudes. Negate an operand only when it is signed for the op (MULH: both; MULHSU: rs1 only; DIV/REM: both) and negative.
- Fast path (DIV/DIVU/REM/REMU only), decided at accept, next state DONE:
  - rs2==0: quotient = all ones; remainder = rs1 unmodified.
  - DIV/REM with rs1 == 1<<(XLEN-1) and rs2 == all ones: quotient = rs1; remainder = 0.
  - out_valid is high after 1 edge.
- Normal path: accept → RUN with counter=0.
  - Each RUN edge retires BITS_PER_CYCLE bits.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring divide into quotient and partial remainder.
  - After ITER RUN edges → FIX.
- FIX: apply sign correction in one cycle (two's-complement negate) → DONE.
  - MUL*: negate the 2*XLEN product when the operand signs differ (after signedness masking).
  - DIV: negate the quotient when the signs differ.
  - REM: the remainder takes the dividend's sign.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Latency: accept edge to out_valid visible = ITER+2 edges. This is 34 for XLEN=32, BITS_PER_CYCLE=1.
- DONE:
  - out_valid=1; out_result and out_tag are stable.
  - Leaves to IDLE on the edge where out_ready=1. out_valid drops that edge.
  - While out_ready=0, the unit holds indefinitely and results must not change.
- No accept in the same cycle as the DONE handshake; in_ready becomes 1 the cycle after. Back-to-back throughput is therefore one op per ITER+3 cycles.
- flush:
  - In RUN, FIX or DONE, the next edge goes to IDLE and clears out_valid. The result is discarded and no handshake occurs.
  - flush in IDLE blocks acceptance even when in_valid=1.
  - flush has priority over out_ready in DONE.
- Outputs are registered. in_ready and busy are decoded from state only, never combinationally from in_valid.
- Deassertion of reset mid-operation resumes from IDLE. No partial result is ever presented.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD, tag 5 → out_result=0xFFFFFFEB and out_tag=5, with out_valid on edge 34 after accept (B=1). Repeat with BITS_PER_CYCLE=4 → edge 10.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
3. DIVU 100/7 → 14; REMU 100/7 → 2; DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
4. DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both on the first edge after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
5. Hold out_ready=0 for 10 cycles in DONE → out_valid, out_result and out_tag stay constant and in_ready=0. Raise out_ready → IDLE next edge, then accept a new op.
6. flush at RUN cycle 12 → IDLE next edge with no out_valid. Separately, pull reset low mid-RUN → all outputs 0 immediately (asynchronous) and in_ready=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Operands are converted to magnitudes at accept. The unit then runs an unsigned
// shift-add multiply or a restoring divide, retiring BITS_PER_CYCLE bits per cycle.
// The sign is fixed up in one extra cycle.
// Divide-by-zero and signed overflow bypass the iteration and go straight to DONE.
// BITS_PER_CYCLE must be 1, 2 or 4 and must divide XLEN.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sa_q, sa_d;          // rs1 treated as signed and negative
  logic               sb_q, sb_d;          // rs2 treated as signed and negative
  logic [XLEN-1:0]    op_q, op_d;          // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]  acc_q, acc_d;        // {product hi, multiplier/product lo} or {remainder, quotient}
  logic [XLEN-1:0]    res_q, res_d;

  // One multiply step.
  // The low half of acc holds the remaining multiplier bits. The high half
  // accumulates the product, and the whole register shifts right by one.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   m);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    return {sum, acc[XLEN-1:1]};
  endfunction

  // One restoring-divide step.
  // Shift the next dividend bit into the partial remainder. Subtract the
  // divisor only when it fits, and record that decision as the quotient bit.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   d);
    logic [XLEN:0]   sh;
    logic            ge;
    logic [XLEN-1:0] rem_n;
    sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge    = (sh >= {1'b0, d});
    rem_n = ge ? (sh[XLEN-1:0] - d) : sh[XLEN-1:0];
    return {rem_n, acc[XLEN-2:0], ge};
  endfunction

  // Accept-time decode
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  assign accept   = (state_q == S_IDLE) && in_valid && !flush;
  assign a_neg    = in_rs1[XLEN-1] && ((in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                                       (in_funct3 == 3'd4) || (in_funct3 == 3'd6));
  assign b_neg    = in_rs2[XLEN-1] && ((in_funct3 == 3'd1) || (in_funct3 == 3'd4) ||
                                       (in_funct3 == 3'd6));
  assign a_mag    = a_neg ? -in_rs1 : in_rs1;
  assign b_mag    = b_neg ? -in_rs2 : in_rs2;
  assign div_zero = (in_rs2 == '0);
  assign div_ovf  = !in_funct3[0] && (in_rs1 == INT_MIN) && (in_rs2 == '1);
  assign fast     = in_funct3[2] && (div_zero || div_ovf);
  assign fast_res = div_zero ? (in_funct3[1] ? in_rs1 : '1)
                             : (in_funct3[1] ? '0 : in_rs1);

  // Unrolled chain of BITS_PER_CYCLE single-bit steps per RUN cycle
  logic [2*XLEN-1:0] mul_chain [BITS_PER_CYCLE+1];
  logic [2*XLEN-1:0] div_chain [BITS_PER_CYCLE+1];

  assign mul_chain[0] = acc_q;
  assign div_chain[0] = acc_q;

  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      assign mul_chain[gi+1] = mul_step(mul_chain[gi], op_q);
      assign div_chain[gi+1] = div_step(div_chain[gi], op_q);
    end
  endgenerate

  // Sign fix-up applied in FIX
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot, rem, fix_res;

  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quot     = acc_q[XLEN-1:0];
  assign rem      = acc_q[2*XLEN-1:XLEN];

  // Select the architectural result after sign correction
  always_comb begin
    fix_res = '0;
    if (!funct3_q[2]) begin
      fix_res = (funct3_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else if (funct3_q[1]) begin
      fix_res = sa_q ? -rem : rem;
    end else begin
      fix_res = (sa_q ^ sb_q) ? -quot : quot;
    end
  end

  // Next-state logic: flush wins over everything, and out_ready only matters in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = fast ? S_DONE : S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX:   state_d = flush ? S_IDLE : S_DONE;
      S_DONE:  if (flush || out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_DONE);
  end

  // Datapath next-state: capture at accept, iterate in RUN, finalise in FIX
  always_comb begin
    funct3_d = funct3_q;
    tag_d    = tag_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    op_d     = op_q;
    acc_d    = acc_q;
    res_d    = res_q;
    if (accept) begin
      funct3_d = in_funct3;
      tag_d    = in_tag;
      sa_d     = a_neg;
      sb_d     = b_neg;
      if (in_funct3[2]) begin
        op_d  = b_mag;
        acc_d = {{XLEN{1'b0}}, a_mag};
      end else begin
        op_d  = a_mag;
        acc_d = {{XLEN{1'b0}}, b_mag};
      end
      if (fast) res_d = fast_res;
    end
    if (state_q == S_RUN) acc_d = funct3_q[2] ? div_chain[BITS_PER_CYCLE] : mul_chain[BITS_PER_CYCLE];
    if (state_q == S_FIX) res_d = fix_res;
  end

  // Control registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      funct3_q <= '0;
      tag_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      op_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else begin
      funct3_q <= funct3_d;
      tag_q    <= tag_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_tag    = tag_q;

endmodule
